// File: rtl/spatial_filter_pkg.sv
// Shared types and sizing helpers for the spatial filter pixel source.
// FSM encoding plus width functions for the credit, column and row counters.
package spatial_filter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_CREDIT = 2'd1,
    SEND_LINE   = 2'd2,
    FLUSH       = 2'd3
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Credits can climb to one per line plus the primed lines.
  function automatic int credit_width(input int height, input int prime);
    return $clog2(height + prime + 1);
  endfunction

endpackage

// File: rtl/stream_prefetch_buffer.sv
// Two-entry prefetch FIFO sitting between a one-cycle-latency memory and an
// AXI-Stream master port; grants new reads only when they are sure to fit.
module stream_prefetch_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_issue,
  input  logic              rd_last,
  input  logic [DATA_W-1:0] rd_data,
  output logic              issue_permit,
  output logic              drained,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  logic                   in_flight_q;
  logic                   in_flight_last_q;
  logic [1:0]             count_q;
  logic                   rd_ptr_q;
  logic                   wr_ptr_q;
  logic [1:0][DATA_W-1:0] data_q;
  logic [1:0]             last_q;
  logic                   pop;
  logic [1:0]             held_after_pop;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = m_valid ? data_q[rd_ptr_q] : '0;
  assign m_last  = m_valid && last_q[rd_ptr_q];
  assign pop     = m_valid && m_ready;

  // Entries left after this cycle's pop plus the word landing this cycle.
  assign held_after_pop = count_q - {1'b0, pop};
  assign issue_permit   = ({1'b0, held_after_pop} + {2'b00, in_flight_q}) < 3'd2;
  assign drained        = pop && (count_q == 2'd1) && !in_flight_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      count_q          <= 2'd0;
      rd_ptr_q         <= 1'b0;
      wr_ptr_q         <= 1'b0;
      data_q           <= '0;
      last_q           <= '0;
    end else begin
      in_flight_q      <= rd_issue;
      in_flight_last_q <= rd_last;
      if (in_flight_q) begin
        data_q[wr_ptr_q] <= rd_data;
        last_q[wr_ptr_q] <= in_flight_last_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, in_flight_q} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/spatial_filter_stream_source.sv
// Streams a raster frame from frame memory to the spatial filter, one line per
// credit; credits are primed on start and refilled by line-freed pulses.
module spatial_filter_stream_source
  import spatial_filter_pkg::*;
#(
  parameter int PIXEL_SIZE   = 32,
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 18,
  parameter int PRIME_LINES  = 4
) (
  input  logic                  axis_clk,
  input  logic                  axis_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [PIXEL_SIZE-1:0] i_mem_rd_data,
  input  logic                  i_intr,
  output logic                  o_m_data_valid,
  output logic [PIXEL_SIZE-1:0] o_m_data,
  output logic                  o_m_last,
  input  logic                  i_m_ready
);

  localparam int CREDIT_W = credit_width(IMAGE_HEIGHT, PRIME_LINES);
  localparam int COL_W    = cnt_width(IMAGE_WIDTH);
  localparam int ROW_W    = cnt_width(IMAGE_HEIGHT);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX   = '1;
  localparam logic [CREDIT_W-1:0] CREDIT_PRIME = CREDIT_W'(PRIME_LINES);
  localparam logic [COL_W-1:0]    COL_LAST     = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST     = ROW_W'(IMAGE_HEIGHT - 1);

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credits_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic                  done_q;
  logic                  issue, consume, start_frame, credit_inc;
  logic                  line_end, issue_permit, drained;

  assign line_end   = (col_q == COL_LAST);
  assign credit_inc = i_intr && (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    consume     = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          start_frame = 1'b1;
          state_d     = WAIT_CREDIT;
        end
      end
      WAIT_CREDIT: begin
        if ((credits_q != '0) && issue_permit) begin
          consume = 1'b1;
          issue   = 1'b1;
          state_d = SEND_LINE;
        end
      end
      SEND_LINE: issue = issue_permit;
      FLUSH:     if (drained) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // The last read of a line decides where the frame goes next.
    if (issue && line_end) state_d = (row_q == ROW_LAST) ? FLUSH : WAIT_CREDIT;
  end

  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FLUSH) && drained;
      if (start_frame) begin
        addr_q <= i_base_addr;
        col_q  <= '0;
        row_q  <= '0;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (line_end) begin
          col_q <= '0;
          row_q <= row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // A refill and a consume in the same cycle cancel out.
  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      credits_q <= '0;
    end else if (start_frame) begin
      credits_q <= CREDIT_PRIME;
    end else if (credit_inc && !consume) begin
      if (credits_q != CREDIT_MAX) credits_q <= credits_q + CREDIT_W'(1);
    end else if (consume && !credit_inc) begin
      credits_q <= credits_q - CREDIT_W'(1);
    end
  end

  stream_prefetch_buffer #(
    .DATA_W(PIXEL_SIZE)
  ) u_prefetch (
    .clk          (axis_clk),
    .rst          (axis_reset),
    .rd_issue     (issue),
    .rd_last      (issue && line_end),
    .rd_data      (i_mem_rd_data),
    .issue_permit (issue_permit),
    .drained      (drained),
    .m_valid      (o_m_data_valid),
    .m_data       (o_m_data),
    .m_last       (o_m_last),
    .m_ready      (i_m_ready)
  );

  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;
  assign o_mem_rd_en = issue;
  assign o_mem_addr  = addr_q;

endmodule

// File: tb/tb_spatial_filter_stream_source.sv
// Directed bench for spatial_filter_stream_source: 4x6 frame, mem[a]=a, base 0x100.
module tb_spatial_filter_stream_source;

  localparam int W = 4;
  localparam int H = 6;
  localparam int P = 4;
  localparam int AW = 18;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = 18'h100;
  logic          o_busy, o_done, o_mem_rd_en;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] i_mem_rd_data = '0;
  logic          i_intr = 1'b0;
  logic          o_m_data_valid;
  logic [DW-1:0] o_m_data;
  logic          o_m_last;
  logic          i_m_ready = 1'b0;

  always #5 clk = ~clk;

  spatial_filter_stream_source #(
    .PIXEL_SIZE(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .ADDR_WIDTH(AW), .PRIME_LINES(P)
  ) dut (
    .axis_clk       (clk),
    .axis_reset     (rst),
    .i_start        (i_start),
    .i_base_addr    (i_base_addr),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_addr     (o_mem_addr),
    .i_mem_rd_data  (i_mem_rd_data),
    .i_intr         (i_intr),
    .o_m_data_valid (o_m_data_valid),
    .o_m_data       (o_m_data),
    .o_m_last       (o_m_last),
    .i_m_ready      (i_m_ready)
  );

  // Frame memory model: synchronous read, mem[a] = a.
  always @(posedge clk) if (o_mem_rd_en) i_mem_rd_data <= DW'(o_mem_addr);

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          got_last_q[$];
  int cyc = 0, start_cyc = 0, done_cyc = -1, done_cnt = 0;
  int last_acc_cyc = -1, first_acc_cyc = -1;
  int vectors = 0, miscompares = 0;

  // ---------------- driver tasks ----------------
  task automatic tick(input logic r, input logic intr, input logic st);
    @(negedge clk);
    i_m_ready = r;
    i_intr    = intr;
    i_start   = st;
    cyc++;
    #1;
    if (o_m_data_valid && r) begin
      got_q.push_back(o_m_data);
      got_last_q.push_back(o_m_last);
      last_acc_cyc = cyc;
      if (got_q.size() == 1) first_acc_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_last_q.delete();
    exp_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_acc_cyc = -1;
    first_acc_cyc = -1;
  endtask

  task automatic start_frame();
    clear_obs();
    tick(1'b1, 1'b0, 1'b1);
    start_cyc = cyc;
  endtask

  task automatic run_to(input int rel);
    while (cyc - start_cyc < rel) tick(1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({o_busy, o_done, o_mem_rd_en, o_m_data_valid, o_m_last} !== 5'b0 ||
        o_mem_addr !== '0 || o_m_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy %b done %b rd %b valid %b last %b addr %0h data %0h, expected all 0",
               o_busy, o_done, o_mem_rd_en, o_m_data_valid, o_m_last, o_mem_addr, o_m_data);
    end
    rst = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    vectors++;
    if (o_busy !== 1'b0 || o_m_data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy %b valid %b, expected 0 0", o_busy, o_m_data_valid);
    end
  endtask

  task automatic test_primed_lines();
    start_frame();
    run_to(24);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + i);
    vectors++;
    if (got_q.size() != 16) begin
      miscompares++;
      $display("FAIL primed_count: got %0d beats, expected 16", got_q.size());
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== ((i % W) == W - 1)) begin
        miscompares++;
        $display("FAIL primed_beat[%0d]: data %0h last %b, expected data %0h last %b",
                 i, got_q[i], got_last_q[i], exp_q[i], ((i % W) == W - 1));
      end
    end
    vectors++;
    if (first_acc_cyc - start_cyc != 3) begin
      miscompares++;
      $display("FAIL first_beat_latency: got %0d cycles, expected 3", first_acc_cyc - start_cyc);
    end
    vectors++;
    if (o_m_data_valid !== 1'b0 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL primed_stall: valid %b busy %b, expected valid 0 busy 1", o_m_data_valid, o_busy);
    end
  endtask

  task automatic test_credit_return();
    got_q.delete();
    got_last_q.delete();
    exp_q.delete();
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    run_to(45);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h110 + i);
    vectors++;
    if (got_q.size() != 8) begin
      miscompares++;
      $display("FAIL credit_count: got %0d beats, expected 8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== ((i % W) == W - 1)) begin
        miscompares++;
        $display("FAIL credit_beat[%0d]: data %0h last %b, expected data %0h last %b",
                 i, got_q[i], got_last_q[i], exp_q[i], ((i % W) == W - 1));
      end
    end
    vectors++;
    if (done_cnt != 1 || done_cyc - start_cyc != 36 || done_cyc != last_acc_cyc + 1) begin
      miscompares++;
      $display("FAIL credit_done: count %0d at cycle %0d (last accept %0d), expected 1 at cycle 36 (last accept 35)",
               done_cnt, done_cyc - start_cyc, last_acc_cyc - start_cyc);
    end
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_busy: busy %b, expected 0", o_busy);
    end
  endtask

  task automatic test_backpressure();
    logic          prev_stall, prev_last, r;
    logic [DW-1:0] prev_data;
    int            k;
    start_frame();
    k = 1;
    while (got_q.size() < 24 && k < 250) begin
      prev_stall = o_m_data_valid && !i_m_ready;
      prev_data  = o_m_data;
      prev_last  = o_m_last;
      if (k < 4)      r = (k % 2 == 0);
      else if (k < 9) r = 1'b0;
      else            r = (k % 3 != 2);
      tick(r, (k == 40 || k == 41), 1'b0);
      if (prev_stall) begin
        vectors++;
        if (o_m_data_valid !== 1'b1 || o_m_data !== prev_data || o_m_last !== prev_last) begin
          miscompares++;
          $display("FAIL stall_hold[k=%0d]: valid %b data %0h last %b, expected 1 %0h %b",
                   k, o_m_data_valid, o_m_data, o_m_last, prev_data, prev_last);
        end
      end
      k++;
    end
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) exp_q.push_back(32'h100 + i);
    vectors++;
    if (got_q.size() != 24) begin
      miscompares++;
      $display("FAIL stall_count: got %0d beats, expected 24", got_q.size());
    end
    for (int i = 0; i < 24 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== ((i % W) == W - 1)) begin
        miscompares++;
        $display("FAIL stall_beat[%0d]: data %0h last %b, expected data %0h last %b",
                 i, got_q[i], got_last_q[i], exp_q[i], ((i % W) == W - 1));
      end
    end
    vectors++;
    if (done_cnt != 1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_done: done count %0d busy %b, expected 1 and 0", done_cnt, o_busy);
    end
  endtask

  task automatic test_credit_collision();
    start_frame();
    tick(1'b1, 1'b1, 1'b0);  // refill lands in the first consume cycle
    run_to(30);
    vectors++;
    if (got_q.size() != 20 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_lines: got %0d beats busy %b, expected 20 beats busy 1", got_q.size(), o_busy);
    end
    tick(1'b1, 1'b1, 1'b0);
    run_to(50);
    vectors++;
    if (got_q.size() != 24 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL collision_finish: got %0d beats done %0d, expected 24 beats done 1", got_q.size(), done_cnt);
    end
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    clear_obs();
    tick(1'b1, 1'b1, 1'b1);
    start_cyc = cyc;
    run_to(30);
    vectors++;
    if (got_q.size() != 16 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_intr: got %0d beats busy %b, expected 16 beats busy 1", got_q.size(), o_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    rst = 1'b1;
    repeat (2) tick(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    start_frame();
    guard = 0;
    while (got_q.size() < 6 && guard < 40) begin
      tick(1'b1, 1'b0, 1'b0);
      guard++;
    end
    vectors++;
    if (got_q.size() != 6) begin
      miscompares++;
      $display("FAIL midreset_reach: got %0d beats, expected 6", got_q.size());
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({o_busy, o_done, o_mem_rd_en, o_m_data_valid, o_m_last} !== 5'b0 ||
        o_mem_addr !== '0 || o_m_data !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: busy %b done %b rd %b valid %b last %b addr %0h data %0h, expected all 0",
               o_busy, o_done, o_mem_rd_en, o_m_data_valid, o_m_last, o_mem_addr, o_m_data);
    end
    repeat (2) tick(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    start_frame();
    run_to(24);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + i);
    vectors++;
    if (got_q.size() != 16) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d beats, expected 16", got_q.size());
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midreset_beat[%0d]: data %0h, expected %0h", i, got_q[i], exp_q[i]);
      end
    end
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    run_to(45);
    vectors++;
    if (done_cnt != 1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_done: done count %0d busy %b, expected 1 and 0", done_cnt, o_busy);
    end
  endtask

  task automatic test_start_while_busy();
    int rel;
    start_frame();
    for (rel = 1; rel <= 45; rel++) begin
      i_base_addr = (rel == 5 || rel == 20 || rel == 30) ? 18'h200 : 18'h100;
      tick(1'b1, (rel == 25 || rel == 26), (rel == 5 || rel == 20 || rel == 30));
    end
    i_base_addr = 18'h100;
    for (int i = 0; i < 24; i++) exp_q.push_back(32'h100 + i);
    vectors++;
    if (got_q.size() != 24) begin
      miscompares++;
      $display("FAIL busy_start_count: got %0d beats, expected 24", got_q.size());
    end
    for (int i = 0; i < 24 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== ((i % W) == W - 1)) begin
        miscompares++;
        $display("FAIL busy_start_beat[%0d]: data %0h last %b, expected data %0h last %b",
                 i, got_q[i], got_last_q[i], exp_q[i], ((i % W) == W - 1));
      end
    end
    vectors++;
    if (done_cnt != 1 || done_cyc - start_cyc != 36 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_done: count %0d at cycle %0d busy %b, expected 1 at cycle 36 busy 0",
               done_cnt, done_cyc - start_cyc, o_busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_primed_lines();
    test_credit_return();
    test_backpressure();
    test_credit_collision();
    test_reset_mid_frame();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
